// File: rtl/branch_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_pkg
//   Shared definitions for the branch redirect controller.
//   - state_t          : controller FSM state encoding
//   - PC_W_DEF         : default PC / redirect address width
//   - DRAIN_CYCLES_DEF : default number of unstalled drain cycles after halt
//   - CNT_W            : width of the drain counter
// -----------------------------------------------------------------------------
package branch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int PC_W_DEF         = 32;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//   Turns a taken branch / halt from the branch lane EX stage into a one-cycle
//   PC redirect strobe plus decode squash, and sequences the halt drain.
//
// Parameters
//   PC_W          PC and redirect address width
//   DRAIN_CYCLES  unstalled cycles allowed for the pipeline to drain (1..15)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               pipeline stall; only the pending-redirect capture
//                       advances while it is high
//   branch_taken        EX resolved a taken branch/jump, target on new_pc
//   new_pc              branch target
//   dont_squash_dec     decode-stage instruction survives this redirect
//   dont_squash_exec    EX shadow instruction survives this redirect
//   halt_proc           EX executed halt
//   redirect_valid      one-cycle PC load strobe
//   redirect_pc         PC load value; holds its last value between strobes
//   branch_squash       one-cycle decode squash to all lanes
//   dont_squash_dec_in  qualifier for branch_squash
//   fetch_en            PC increment / fetch enable
//   halted              sticky halted flag
//
// Strobe semantics: redirect_valid is a pure one-cycle pulse with no
// back-pressure; redirect_pc, branch_squash and dont_squash_dec_in are only
// meaningful in the cycle redirect_valid is high. Two strobes are never issued
// in consecutive cycles: a branch accepted while a strobe is already being
// driven (the shadow branch in SQUASH) is parked in the pending buffer and
// issued on the following cycle.
//
// The FSM state is visible as the internal signal `state` for debug/checkers.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] new_pc,
    input  logic            dont_squash_dec,
    input  logic            dont_squash_exec,
    input  logic            halt_proc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            branch_squash,
    output logic            dont_squash_dec_in,
    output logic            fetch_en,
    output logic            halted
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t            state;
    logic              pend_v;
    logic [PC_W-1:0]   pend_pc;
    logic              pend_dsd;
    logic              pend_dse;
    logic              dse_q;       // dont_squash_exec of the redirect in flight
    logic [CNT_W-1:0]  cnt;

    logic active;
    logic halt_go;
    logic br_accept;
    logic issue_pend;
    logic issue_new;
    logic capture;

    always_comb begin
        active    = (state == ST_RUN) || (state == ST_SQUASH);
        halt_go   = active && halt_proc && !stall;
        // In SQUASH the EX instruction is the shadow of the redirect; its
        // branch only counts if that redirect said the shadow survives.
        br_accept = branch_taken && !pend_v &&
                    ((state == ST_RUN) || ((state == ST_SQUASH) && dse_q));
        issue_pend = active && pend_v && !stall && !redirect_valid && !halt_go;
        issue_new  = active && br_accept && !stall && !redirect_valid && !halt_go;
        capture    = active && br_accept && (stall || redirect_valid) && !halt_go;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_RUN;
            pend_v             <= 1'b0;
            pend_pc            <= '0;
            pend_dsd           <= 1'b0;
            pend_dse           <= 1'b0;
            dse_q              <= 1'b0;
            cnt                <= '0;
            redirect_valid     <= 1'b0;
            redirect_pc        <= '0;
            branch_squash      <= 1'b0;
            dont_squash_dec_in <= 1'b0;
            fetch_en           <= 1'b1;
            halted             <= 1'b0;
        end else begin
            redirect_valid     <= 1'b0;
            branch_squash      <= 1'b0;
            dont_squash_dec_in <= 1'b0;

            case (state)
                ST_RUN, ST_SQUASH: begin
                    if (halt_go) begin
                        // Halt wins over any branch; the pending redirect is dropped.
                        state    <= ST_DRAIN;
                        cnt      <= DRAIN_LOAD;
                        fetch_en <= 1'b0;
                        pend_v   <= 1'b0;
                    end else if (issue_pend) begin
                        redirect_valid     <= 1'b1;
                        redirect_pc        <= pend_pc;
                        branch_squash      <= 1'b1;
                        dont_squash_dec_in <= pend_dsd;
                        dse_q              <= pend_dse;
                        pend_v             <= 1'b0;
                        state              <= ST_SQUASH;
                    end else if (issue_new) begin
                        redirect_valid     <= 1'b1;
                        redirect_pc        <= new_pc;
                        branch_squash      <= 1'b1;
                        dont_squash_dec_in <= dont_squash_dec;
                        dse_q              <= dont_squash_exec;
                        state              <= ST_SQUASH;
                    end else begin
                        if (capture) begin
                            pend_v   <= 1'b1;
                            pend_pc  <= new_pc;
                            pend_dsd <= dont_squash_dec;
                            pend_dse <= dont_squash_exec;
                        end
                        // SQUASH consumes exactly one unstalled cycle.
                        if ((state == ST_SQUASH) && !stall) begin
                            state <= ST_RUN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (!stall) begin
                        if (cnt == '0) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end

                default: begin
                    // HALTED: everything ignored until reset.
                end
            endcase
        end
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter PC_W, default 32: PC and redirect address width.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 3: cycles allowed for the pipeline to drain after halt, legal range 1..15.
REQ-003 The block SHALL have one clock and a synchronous active-high reset:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these remaining ports:
- stall  in  1  pipeline stall; while high, no state advances except the pending-redirect capture.
- branch_taken  in  1  branch lane EX resolved a taken branch or jump.
- new_pc  in  PC_W  branch target, valid with branch_taken.
- dont_squash_dec  in  1  the decode-stage instruction survives the redirect.
- dont_squash_exec  in  1  the EX-stage shadow instruction survives the redirect.
- halt_proc  in  1  branch lane EX executed halt.
- redirect_valid  out  1  one-cycle PC load strobe.
- redirect_pc  out  PC_W  PC load value, valid with redirect_valid.
- branch_squash  out  1  squash the decode stage in all lanes, one cycle.
- dont_squash_dec_in  out  1  qualifies branch_squash, driven to the lanes.
- fetch_en  out  1  PC increment and fetch enable.
- halted  out  1  processor halted; sticky.

Function
REQ-005 The block SHALL implement the FSM states RUN, SQUASH, DRAIN and HALTED, encoded as an enum.
REQ-006 In RUN with branch_taken=1, stall=0 and halt_proc=0, the block SHALL register the redirect and, on the next cycle, assert redirect_valid=1, redirect_pc=new_pc, branch_squash=1 and dont_squash_dec_in equal to the registered dont_squash_dec, then enter SQUASH. Latency from branch_taken to the strobe is exactly 1 cycle.
REQ-007 If branch_taken=1 while stall=1, the block SHALL capture new_pc and dont_squash_dec into a one-entry pending buffer (pend_v=1) and SHALL NOT strobe.
REQ-008 On the first cycle in which stall=0 and pend_v=1, the block SHALL issue the pending redirect as in REQ-006 and clear pend_v; the strobe SHALL appear 1 cycle after stall falls.
REQ-009 While pend_v=1, further branch_taken assertions SHALL be ignored, so the stalled branch is never issued twice and the first capture wins.
REQ-010 SQUASH SHALL last exactly one unstalled cycle. During it, branch_taken SHALL be ignored unless the registered dont_squash_exec=1, in which case it is handled as in RUN. SQUASH then returns to RUN.
REQ-011 In RUN or SQUASH with halt_proc=1 and stall=0, the block SHALL enter DRAIN, drive fetch_en=0 from the next cycle, and load the drain counter with DRAIN_CYCLES-1.
REQ-012 halt_proc SHALL have priority over a simultaneous branch_taken; the branch and any pending redirect SHALL be discarded and no strobe issued.
REQ-013 In DRAIN, the counter SHALL decrement on each cycle with stall=0 and hold on each cycle with stall=1. At count 0 with stall=0, the block SHALL enter HALTED.
REQ-014 Drain duration SHALL be exactly DRAIN_CYCLES unstalled cycles from DRAIN entry. The counter SHALL be 4 bits and never wrap below 0.
REQ-015 In HALTED, the block SHALL drive halted=1 and fetch_en=0, and all inputs SHALL be ignored until rst.
REQ-016 fetch_en SHALL be 1 in RUN and SQUASH, and 0 in DRAIN and HALTED.
REQ-017 redirect_valid and branch_squash SHALL never be high for two consecutive cycles.
REQ-018 redirect_pc SHALL hold its last value when redirect_valid=0.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL set state=RUN, pend_v=0, counter=0, redirect_valid=0, redirect_pc=0, branch_squash=0, dont_squash_dec_in=0, fetch_en=1 and halted=0.
REQ-020 Reset SHALL take effect mid-DRAIN, mid-SQUASH or with a pending redirect, discarding all in-flight state; fetch_en=1 in the first cycle after reset.

Structure
REQ-021 The shared branch package SHALL hold the FSM state enum and the default-parameter constants (PC_W, DRAIN_CYCLES default).
REQ-022 The block SHALL be a single module with no sub-modules; the pending buffer and drain counter SHALL be inline registers.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Taken branch, unstalled: branch_taken=1, new_pc=0x0000_0040, dont_squash_dec=1 -> next cycle redirect_valid=1, redirect_pc=0x40, branch_squash=1, dont_squash_dec_in=1, then state RUN after 1 further cycle.
- Branch under stall: branch_taken=1, new_pc=0x80, stall=1 for 3 cycles (branch_taken held) -> no strobe during stall; exactly one strobe with redirect_pc=0x80 one cycle after stall falls.
- Shadow handling: second branch_taken (new_pc=0xC0) the cycle after a redirect, with dont_squash_exec=0 -> ignored; repeated with dont_squash_exec=1 -> strobe with redirect_pc=0xC0.
- Halt drain, DRAIN_CYCLES=3: halt_proc=1 with a 1-cycle stall inside DRAIN -> fetch_en=0 next cycle; halted=1 exactly 4 cycles after DRAIN entry; branch_taken after that is ignored.
- Halt and branch together: halt_proc=1, branch_taken=1, new_pc=0x100 -> no redirect_valid ever; enters DRAIN.
- Reset mid-DRAIN, with pend_v set beforehand -> next cycle fetch_en=1, halted=0, redirect_valid=0, and no stale redirect after reset.
